parking_timestamp: RTL and testbench

Timestamp producer for the parking controller. Keeps the system time base, records each car's entry time per parking slot, and on exit emits the `{time_in, time_out}` pair to `time_calculate` over a valid/ready handshake. `time_calculate` then forms the duration as `time_out - time_in` modulo 256. Sits between the gate/sensor logic, which issues the entry and exit requests, and the billing path.

---
 rtl/parking_pkg.sv | 13 +
 rtl/parking_tick_counter.sv | 34 +++
 rtl/parking_timestamp.sv | 100 ++++++++++
 tb/tb_parking_timestamp.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parking_pkg.sv
// Shared types and defaults for the parking timestamp producer.
package parking_pkg;

  localparam int unsigned TIME_W       = 8;
  localparam int unsigned DEF_SLOTS    = 4;
  localparam int unsigned DEF_TICK_DIV = 50;

  typedef enum logic [0:0] {
    IDLE,
    VALID
  } state_e;

endpackage

// File: rtl/parking_tick_counter.sv
// System time base: prescaler dividing clk by TICK_DIV, and the 8-bit wrapping time unit.
module parking_tick_counter
  import parking_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [TIME_W-1:0] now,
  output logic              tick
);

  // Keep the prescaler at least one bit wide so TICK_DIV=1 still elaborates.
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]     presc_q;
  logic [TIME_W-1:0] now_q;

  assign tick = (presc_q == PW'(TICK_DIV - 1));
  assign now  = now_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
      now_q   <= '0;
    end else if (tick) begin
      presc_q <= '0;
      now_q   <= now_q + 8'd1;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

endmodule

// File: rtl/parking_timestamp.sv
// Per-slot entry stamps and occupancy; emits {time_in, time_out} on exit over valid/ready.
module parking_timestamp
  import parking_pkg::*;
#(
  parameter int unsigned SLOTS    = DEF_SLOTS,
  parameter int unsigned TICK_DIV = DEF_TICK_DIV,
  parameter int unsigned SW       = $clog2(SLOTS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              entry_req,
  input  logic [SW-1:0]     entry_slot,
  input  logic              exit_req,
  input  logic [SW-1:0]     exit_slot,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [TIME_W-1:0] time_in,
  output logic [TIME_W-1:0] time_out,
  output logic [SW-1:0]     out_slot,
  output logic [SLOTS-1:0]  occupied,
  output logic [TIME_W-1:0] now,
  output logic              err
);

  logic [TIME_W-1:0] stamp_q [SLOTS];
  logic [SLOTS-1:0]  occupied_q;
  state_e            state_q;
  logic [TIME_W-1:0] time_in_q;
  logic [TIME_W-1:0] time_out_q;
  logic [SW-1:0]     out_slot_q;
  logic              err_q;

  logic same_slot;
  logic exit_ok;
  logic entry_ok;
  logic err_d;

  parking_tick_counter #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .now  (now),
    .tick ()
  );

  // Exit wins on a shared slot: the entry is refused whether or not the exit succeeds.
  always_comb begin
    same_slot = exit_req && (exit_slot == entry_slot);
    exit_ok   = exit_req && occupied_q[exit_slot] && (state_q == IDLE);
    entry_ok  = entry_req && !occupied_q[entry_slot] && !same_slot;
    err_d     = (entry_req && !entry_ok) || (exit_req && !exit_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < SLOTS; i++) begin
        stamp_q[i] <= '0;
      end
      occupied_q <= '0;
      state_q    <= IDLE;
      time_in_q  <= '0;
      time_out_q <= '0;
      out_slot_q <= '0;
      err_q      <= 1'b0;
    end else begin
      err_q <= err_d;
      if (entry_ok) begin
        stamp_q[entry_slot]    <= now;
        occupied_q[entry_slot] <= 1'b1;
      end
      if (exit_ok) begin
        occupied_q[exit_slot] <= 1'b0;
      end
      unique case (state_q)
        IDLE: begin
          if (exit_ok) begin
            time_in_q  <= stamp_q[exit_slot];
            time_out_q <= now;
            out_slot_q <= exit_slot;
            state_q    <= VALID;
          end
        end
        VALID: begin
          if (out_ready) begin
            state_q <= IDLE;
          end
        end
      endcase
    end
  end

  assign out_valid = (state_q == VALID);
  assign time_in   = time_in_q;
  assign time_out  = time_out_q;
  assign out_slot  = out_slot_q;
  assign occupied  = occupied_q;
  assign err       = err_q;

endmodule

// File: tb/tb_parking_timestamp.sv
// Directed bench for parking_timestamp with TICK_DIV=2, SLOTS=4.
module tb_parking_timestamp;

  logic       clk;
  logic       rst_n;
  logic       entry_req;
  logic [1:0] entry_slot;
  logic       exit_req;
  logic [1:0] exit_slot;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] time_in;
  logic [7:0] time_out;
  logic [1:0] out_slot;
  logic [3:0] occupied;
  logic [7:0] now;
  logic       err;

  int n_tests;
  int n_fail;
  int cyc;

  parking_timestamp #(
    .SLOTS   (4),
    .TICK_DIV(2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .entry_req (entry_req),
    .entry_slot(entry_slot),
    .exit_req  (exit_req),
    .exit_slot (exit_slot),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .time_in   (time_in),
    .time_out  (time_out),
    .out_slot  (out_slot),
    .occupied  (occupied),
    .now       (now),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Time unit expected after cyc edges since reset release (two clocks per unit).
  function automatic logic [7:0] exp_now();
    return 8'(cyc / 2);
  endfunction

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic go_to(input logic [7:0] t);
    while (exp_now() != t) step(1);
  endtask

  task automatic do_reset();
    entry_req = 1'b0; exit_req = 1'b0; out_ready = 1'b0;
    entry_slot = 2'd0; exit_slot = 2'd0;
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic do_entry(input logic [1:0] s);
    entry_req = 1'b1; entry_slot = s;
    step(1);
    entry_req = 1'b0;
  endtask

  task automatic do_exit(input logic [1:0] s);
    exit_req = 1'b1; exit_slot = s;
    step(1);
    exit_req = 1'b0;
  endtask

  task automatic accept();
    out_ready = 1'b1;
    step(1);
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    entry_req = 1'b0; exit_req = 1'b0; out_ready = 1'b0;
    entry_slot = 2'd0; exit_slot = 2'd0;
    @(posedge clk);
    #1;
    n_tests++;
    if ({out_valid, time_in, time_out, out_slot, occupied, now, err} !== 31'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 0",
               {out_valid, time_in, time_out, out_slot, occupied, now, err});
    end
    #2;
    rst_n = 1'b1;
    cyc = 0;
    step(1);
    n_tests++;
    if ({out_valid, occupied, now, err} !== 14'd0) begin
      n_fail++;
      $display("FAIL release_outputs: got %h expected 0", {out_valid, occupied, now, err});
    end
    step(19);
    n_tests++;
    if (now !== 8'd10) begin
      n_fail++;
      $display("FAIL now_after_20: got %0d expected 10", now);
    end
    go_to(8'd255);
    n_tests++;
    if (now !== 8'd255) begin
      n_fail++;
      $display("FAIL now_255: got %0d expected 255", now);
    end
    step(2);
    n_tests++;
    if (now !== 8'd0) begin
      n_fail++;
      $display("FAIL now_wrap: got %0d expected 0", now);
    end
  endtask

  task automatic test_basic_pair();
    do_reset();
    go_to(8'd1);
    do_entry(2'd1);
    n_tests++;
    if (occupied !== 4'b0010) begin
      n_fail++;
      $display("FAIL basic_occ_set: got %b expected 0010", occupied);
    end
    go_to(8'd25);
    do_exit(2'd1);
    n_tests++;
    if (out_valid !== 1'b1 || time_in !== 8'h01 || time_out !== 8'h19 || out_slot !== 2'd1) begin
      n_fail++;
      $display("FAIL basic_pair: got v=%0d in=%h out=%h slot=%0d expected v=1 in=01 out=19 slot=1",
               out_valid, time_in, time_out, out_slot);
    end
    n_tests++;
    if (occupied !== 4'b0000 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_occ_clr: got occ=%b err=%0d expected occ=0000 err=0", occupied, err);
    end
    n_tests++;
    if (8'(time_out - time_in) !== 8'd24) begin
      n_fail++;
      $display("FAIL basic_duration: got %0d expected 24", 8'(time_out - time_in));
    end
    accept();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_accept: got valid=%0d expected 0", out_valid);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    go_to(8'd250);
    do_entry(2'd0);
    go_to(8'd4);
    do_exit(2'd0);
    n_tests++;
    if (out_valid !== 1'b1 || time_in !== 8'd250 || time_out !== 8'd4 || out_slot !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_pair: got v=%0d in=%0d out=%0d slot=%0d expected v=1 in=250 out=4 slot=0",
               out_valid, time_in, time_out, out_slot);
    end
    n_tests++;
    if (8'(time_out - time_in) !== 8'd10) begin
      n_fail++;
      $display("FAIL wrap_duration: got %0d expected 10", 8'(time_out - time_in));
    end
    accept();
  endtask

  task automatic test_backpressure();
    do_reset();
    go_to(8'd3);
    do_entry(2'd1);
    go_to(8'd5);
    do_entry(2'd2);
    go_to(8'd9);
    do_exit(2'd1);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        exit_req = 1'b1; exit_slot = 2'd2;
      end
      step(1);
      exit_req = 1'b0;
      n_tests++;
      if (out_valid !== 1'b1 || time_in !== 8'd3 || time_out !== 8'd9 || out_slot !== 2'd1) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got v=%0d in=%0d out=%0d slot=%0d expected v=1 in=3 out=9 slot=1",
                 i, out_valid, time_in, time_out, out_slot);
      end
      if (i == 1) begin
        n_tests++;
        if (err !== 1'b1 || occupied !== 4'b0100) begin
          n_fail++;
          $display("FAIL bp_exit_in_valid: got err=%0d occ=%b expected err=1 occ=0100", err, occupied);
        end
      end
      if (i == 2) begin
        n_tests++;
        if (err !== 1'b0) begin
          n_fail++;
          $display("FAIL bp_err_pulse: got err=%0d expected 0", err);
        end
      end
    end
    accept();
    n_tests++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%0d expected 0", out_valid);
    end
    go_to(8'd20);
    do_exit(2'd2);
    n_tests++;
    if (out_valid !== 1'b1 || time_in !== 8'd5 || time_out !== 8'd20 || out_slot !== 2'd2) begin
      n_fail++;
      $display("FAIL bp_slot2_pair: got v=%0d in=%0d out=%0d slot=%0d expected v=1 in=5 out=20 slot=2",
               out_valid, time_in, time_out, out_slot);
    end
    accept();
  endtask

  task automatic test_errors();
    do_reset();
    go_to(8'd2);
    do_entry(2'd3);
    go_to(8'd6);
    do_entry(2'd3);
    n_tests++;
    if (err !== 1'b1 || occupied !== 4'b1000) begin
      n_fail++;
      $display("FAIL err_dup_entry: got err=%0d occ=%b expected err=1 occ=1000", err, occupied);
    end
    step(1);
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL err_single_cycle: got err=%0d expected 0", err);
    end
    go_to(8'd8);
    do_exit(2'd0);
    n_tests++;
    if (err !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL err_free_exit: got err=%0d valid=%0d expected err=1 valid=0", err, out_valid);
    end
    go_to(8'd10);
    do_exit(2'd3);
    n_tests++;
    if (out_valid !== 1'b1 || time_in !== 8'd2 || time_out !== 8'd10 || out_slot !== 2'd3) begin
      n_fail++;
      $display("FAIL err_stamp_kept: got v=%0d in=%0d out=%0d slot=%0d expected v=1 in=2 out=10 slot=3",
               out_valid, time_in, time_out, out_slot);
    end
    accept();
  endtask

  task automatic test_simultaneous();
    do_reset();
    go_to(8'd2);
    do_entry(2'd3);
    go_to(8'd4);
    entry_req = 1'b1; entry_slot = 2'd0;
    exit_req = 1'b1; exit_slot = 2'd3;
    step(1);
    entry_req = 1'b0; exit_req = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_slot !== 2'd3 || time_in !== 8'd2 || time_out !== 8'd4
        || occupied !== 4'b0001 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_diff_slots: got v=%0d slot=%0d in=%0d out=%0d occ=%b err=%0d expected 1 3 2 4 0001 0",
               out_valid, out_slot, time_in, time_out, occupied, err);
    end
    accept();
    go_to(8'd6);
    do_entry(2'd2);
    go_to(8'd8);
    entry_req = 1'b1; entry_slot = 2'd2;
    exit_req = 1'b1; exit_slot = 2'd2;
    step(1);
    entry_req = 1'b0; exit_req = 1'b0;
    n_tests++;
    if (out_valid !== 1'b1 || out_slot !== 2'd2 || time_in !== 8'd6 || time_out !== 8'd8
        || occupied !== 4'b0001 || err !== 1'b1) begin
      n_fail++;
      $display("FAIL sim_same_slot: got v=%0d slot=%0d in=%0d out=%0d occ=%b err=%0d expected 1 2 6 8 0001 1",
               out_valid, out_slot, time_in, time_out, occupied, err);
    end
    // Drop reset mid-cycle while the pair is still pending.
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 1'b0 || occupied !== 4'b0000 || now !== 8'd0 || err !== 1'b0) begin
      n_fail++;
      $display("FAIL sim_async_reset: got v=%0d occ=%b now=%0d err=%0d expected 0 0000 0 0",
               out_valid, occupied, now, err);
    end
    #1;
    rst_n = 1'b1;
    cyc = 0;
    step(2);
    n_tests++;
    if (out_valid !== 1'b0 || occupied !== 4'b0000 || now !== 8'd1) begin
      n_fail++;
      $display("FAIL sim_after_reset: got v=%0d occ=%b now=%0d expected 0 0000 1",
               out_valid, occupied, now);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    cyc     = 0;
    rst_n   = 1'b0;
    test_reset();
    test_basic_pair();
    test_wrap();
    test_backpressure();
    test_errors();
    test_simultaneous();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
